// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// The result is computed when the op is accepted and committed after a fixed busy window.
module mul_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MDUControl,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        start,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDUOut
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic            busy_q;
  logic [31:0]     hi_q, lo_q;
  logic [31:0]     hin_q, lon_q;
  logic            wr_q;

  logic signed [63:0] as_w, bs_w, prod_s;
  logic        [63:0] prod_u;
  logic signed [31:0] sa32, sb32;
  logic        [31:0] q_s, r_s, q_u, r_u;
  logic               b_zero, s_ovf;
  logic        [31:0] res_hi_d, res_lo_d;
  logic               res_wr_d;
  logic [CW-1:0]      load_d;

  assign start  = (MDUControl == OP_MULT) || (MDUControl == OP_MULTU) ||
                  (MDUControl == OP_DIV)  || (MDUControl == OP_DIVU);
  assign busy   = busy_q;
  assign HI     = hi_q;
  assign LO     = lo_q;
  assign MDUOut = (MDUControl == OP_MFHI) ? hi_q :
                  (MDUControl == OP_MFLO) ? lo_q : 32'h0;

  assign as_w   = {{32{A[31]}}, A};
  assign bs_w   = {{32{B[31]}}, B};
  assign prod_s = as_w * bs_w;
  assign prod_u = {32'h0, A} * {32'h0, B};
  assign sa32   = A;
  assign sb32   = B;
  assign b_zero = (B == 32'h0);
  // Most-negative / -1 overflows the signed divider; pin it to the defined result.
  assign s_ovf  = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);

  always_comb begin
    q_s = 32'h0;
    r_s = 32'h0;
    q_u = 32'h0;
    r_u = 32'h0;
    if (s_ovf) begin
      q_s = 32'h8000_0000;
    end else if (!b_zero) begin
      q_s = sa32 / sb32;
      r_s = sa32 % sb32;
    end
    if (!b_zero) begin
      q_u = A / B;
      r_u = A % B;
    end
  end

  always_comb begin
    res_hi_d = 32'h0;
    res_lo_d = 32'h0;
    res_wr_d = 1'b1;
    load_d   = CW'(MULT_CYCLES);
    case (MDUControl)
      OP_MULT:  begin res_hi_d = prod_s[63:32]; res_lo_d = prod_s[31:0]; end
      OP_MULTU: begin res_hi_d = prod_u[63:32]; res_lo_d = prod_u[31:0]; end
      OP_DIV: begin
        res_hi_d = r_s;
        res_lo_d = q_s;
        res_wr_d = !b_zero;
        load_d   = CW'(DIV_CYCLES);
      end
      OP_DIVU: begin
        res_hi_d = r_u;
        res_lo_d = q_u;
        res_wr_d = !b_zero;
        load_d   = CW'(DIV_CYCLES);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      hi_q    <= 32'h0;
      lo_q    <= 32'h0;
      hin_q   <= 32'h0;
      lon_q   <= 32'h0;
      wr_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            hin_q   <= res_hi_d;
            lon_q   <= res_lo_d;
            wr_q    <= res_wr_d;
            cnt_q   <= load_d;
            busy_q  <= 1'b1;
            state_q <= BUSY;
          end else if (MDUControl == OP_MTHI) begin
            hi_q <= A;
          end else if (MDUControl == OP_MTLO) begin
            lo_q <= A;
          end
        end
        BUSY: begin
          // Every op arriving here is dropped; the hazard unit holds it in D.
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            if (wr_q) begin
              hi_q <= hin_q;
              lo_q <= lon_q;
            end
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
